// File: rtl/calc_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : calc_sequencer_pkg                                     |
// | Purpose : Shared state encodings, key codes and ALU op codes for |
// |           the calculator key sequencer.                          |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package calc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_ALU = 3'd3,
    ST_SHOW     = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_NOP = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [15:0] DISP_ERR = 16'hEEEE;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

  function automatic logic is_oper(input logic [3:0] key);
    return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL);
  endfunction

  function automatic logic [1:0] key_to_op(input logic [3:0] key);
    case (key)
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_shift_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bcd_shift_reg                                          |
// | Purpose : BCD operand register; digits shift in from the right,  |
// |           entry saturates at MAX_DIGITS digits.                  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module bcd_shift_reg #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic [2:0]  i_load_cnt,
  input  logic        i_shift,
  input  logic [3:0]  i_digit,
  output logic [15:0] o_value,
  output logic [2:0]  o_count,
  output logic        o_full
);

  localparam logic [2:0] FULL_CNT = 3'(MAX_DIGITS);

  logic [15:0] r_value;
  logic [2:0]  r_count;
  logic        w_full;

  assign w_full = (r_count >= FULL_CNT);

  // Operand storage: clear beats load beats shift; a full register ignores digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 16'h0000;
      r_count <= 3'd0;
    end else if (i_clr) begin
      r_value <= 16'h0000;
      r_count <= 3'd0;
    end else if (i_load) begin
      r_value <= i_load_val;
      r_count <= i_load_cnt;
    end else if (i_shift && !w_full) begin
      r_value <= {r_value[11:0], i_digit};
      r_count <= r_count + 3'd1;
    end
  end

  assign o_value = r_value;
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : calc_sequencer                                         |
// | Purpose : Keypad-driven calculator sequencer: collects two BCD   |
// |           operands, launches the ALU, shows result or error.     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_code,
  input  logic        i_alu_done,
  input  logic [15:0] i_alu_result,
  input  logic        i_alu_err,
  output logic [15:0] o_operand_a,
  output logic [15:0] o_operand_b,
  output logic [1:0]  o_op_sel,
  output logic        o_alu_start,
  output logic [15:0] o_display,
  output logic [2:0]  o_digit_count,
  output logic        o_error,
  output logic [2:0]  o_state_dbg
);

  localparam int          TW       = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TIMEOUT - 1);
  localparam logic [2:0]  FULL_CNT = 3'(MAX_DIGITS);

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_display, w_display_nxt;
  logic [1:0]    r_op_sel, w_op_nxt;
  logic          r_alu_start, w_start_nxt;
  logic          r_error, w_error_nxt;
  logic [2:0]    r_digit_count, w_cnt_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;

  logic          w_key_digit, w_key_op, w_key_eq, w_key_clr;
  logic          w_a_clr, w_a_load, w_a_shift, w_a_full;
  logic [15:0]   w_a_load_val, w_a_val;
  logic [2:0]    w_a_load_cnt, w_a_cnt;
  logic          w_b_clr, w_b_shift, w_b_full;
  logic [15:0]   w_b_val;
  logic [2:0]    w_b_cnt;

  assign w_key_digit = i_key_valid && is_digit(i_key_code);
  assign w_key_op    = i_key_valid && is_oper(i_key_code);
  assign w_key_eq    = i_key_valid && (i_key_code == KEY_EQ);
  assign w_key_clr   = i_key_valid && (i_key_code == KEY_CLR);

  bcd_shift_reg #(.MAX_DIGITS(MAX_DIGITS)) u_opa (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_a_clr),
    .i_load     (w_a_load),
    .i_load_val (w_a_load_val),
    .i_load_cnt (w_a_load_cnt),
    .i_shift    (w_a_shift),
    .i_digit    (i_key_code),
    .o_value    (w_a_val),
    .o_count    (w_a_cnt),
    .o_full     (w_a_full)
  );

  bcd_shift_reg #(.MAX_DIGITS(MAX_DIGITS)) u_opb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_b_clr),
    .i_load     (1'b0),
    .i_load_val (16'h0000),
    .i_load_cnt (3'd0),
    .i_shift    (w_b_shift),
    .i_digit    (i_key_code),
    .o_value    (w_b_val),
    .o_count    (w_b_cnt),
    .o_full     (w_b_full)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ENTER_A;
      r_display     <= 16'h0000;
      r_op_sel      <= OP_ADD;
      r_alu_start   <= 1'b0;
      r_error       <= 1'b0;
      r_digit_count <= 3'd0;
      r_tmo         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_display     <= w_display_nxt;
      r_op_sel      <= w_op_nxt;
      r_alu_start   <= w_start_nxt;
      r_error       <= w_error_nxt;
      r_digit_count <= w_cnt_nxt;
      r_tmo         <= w_tmo_nxt;
    end
  end

  // Next-state, next-output and operand register controls; clear overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_display_nxt = r_display;
    w_op_nxt      = r_op_sel;
    w_start_nxt   = 1'b0;
    w_cnt_nxt     = r_digit_count;
    w_tmo_nxt     = r_tmo;
    w_a_clr       = 1'b0;
    w_a_load      = 1'b0;
    w_a_load_val  = 16'h0000;
    w_a_load_cnt  = 3'd0;
    w_a_shift     = 1'b0;
    w_b_clr       = 1'b0;
    w_b_shift     = 1'b0;

    if (w_key_clr) begin
      w_state_nxt   = ST_ENTER_A;
      w_display_nxt = 16'h0000;
      w_op_nxt      = OP_ADD;
      w_cnt_nxt     = 3'd0;
      w_tmo_nxt     = '0;
      w_a_clr       = 1'b1;
      w_b_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_ENTER_A: begin
          if (w_key_digit) begin
            if (!w_a_full) begin
              w_a_shift     = 1'b1;
              w_display_nxt = {w_a_val[11:0], i_key_code};
              w_cnt_nxt     = w_a_cnt + 3'd1;
            end
          end else if (w_key_op) begin
            w_op_nxt    = key_to_op(i_key_code);
            w_b_clr     = 1'b1;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (w_key_digit) begin
            if (!w_b_full) begin
              w_b_shift     = 1'b1;
              w_display_nxt = {w_b_val[11:0], i_key_code};
              w_cnt_nxt     = w_b_cnt + 3'd1;
            end
          end else if (w_key_op) begin
            w_op_nxt = key_to_op(i_key_code);
          end else if (w_key_eq) begin
            w_start_nxt = 1'b1;
            w_state_nxt = ST_START;
          end
        end
        ST_START: begin
          w_tmo_nxt   = '0;
          w_state_nxt = ST_WAIT_ALU;
        end
        ST_WAIT_ALU: begin
          if (i_alu_done) begin
            if (i_alu_err) begin
              w_display_nxt = DISP_ERR;
              w_state_nxt   = ST_ERROR;
            end else begin
              w_display_nxt = i_alu_result;
              w_state_nxt   = ST_SHOW;
            end
          end else if (r_tmo == TMO_LAST) begin
            w_display_nxt = DISP_ERR;
            w_state_nxt   = ST_ERROR;
          end else begin
            w_tmo_nxt = r_tmo + TW'(1);
          end
        end
        ST_SHOW: begin
          if (w_key_op) begin
            // Chaining: the shown result becomes the first operand.
            w_a_load     = 1'b1;
            w_a_load_val = r_display;
            w_a_load_cnt = FULL_CNT;
            w_b_clr      = 1'b1;
            w_op_nxt     = key_to_op(i_key_code);
            w_cnt_nxt    = 3'd0;
            w_state_nxt  = ST_ENTER_B;
          end else if (w_key_digit) begin
            w_a_load      = 1'b1;
            w_a_load_val  = {12'h000, i_key_code};
            w_a_load_cnt  = 3'd1;
            w_display_nxt = {12'h000, i_key_code};
            w_cnt_nxt     = 3'd1;
            w_state_nxt   = ST_ENTER_A;
          end
        end
        ST_ERROR: begin
          w_display_nxt = DISP_ERR;
        end
        default: begin
          w_state_nxt = ST_ENTER_A;
        end
      endcase
    end

    w_error_nxt = (w_state_nxt == ST_ERROR);
  end

  assign o_operand_a   = w_a_val;
  assign o_operand_b   = w_b_val;
  assign o_op_sel      = r_op_sel;
  assign o_alu_start   = r_alu_start;
  assign o_display     = r_display;
  assign o_digit_count = r_digit_count;
  assign o_error       = r_error;
  assign o_state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_calc_sequencer                                      |
// | Purpose : Self-checking bench for calc_sequencer; ALU launches   |
// |           are matched against a scoreboard of expected operands. |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_calc_sequencer;

  localparam logic [2:0] S_A = 3'd0, S_B = 3'd1, S_START = 3'd2,
                         S_WAIT = 3'd3, S_SHOW = 3'd4, S_ERR = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0;
  logic        alu_err = 1'b0;
  logic [15:0] operand_a, operand_b, display;
  logic [1:0]  op_sel;
  logic        alu_start, error;
  logic [2:0]  digit_count, state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } launch_t;
  launch_t sb_q[$];
  logic prev_start = 1'b0;

  calc_sequencer #(.MAX_DIGITS(4), .ALU_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_valid   (key_valid),
    .i_key_code    (key_code),
    .i_alu_done    (alu_done),
    .i_alu_result  (alu_result),
    .i_alu_err     (alu_err),
    .o_operand_a   (operand_a),
    .o_operand_b   (operand_b),
    .o_op_sel      (op_sel),
    .o_alu_start   (alu_start),
    .o_display     (display),
    .o_digit_count (digit_count),
    .o_error       (error),
    .o_state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // Scoreboard: every ALU launch must match the oldest expected launch, one cycle wide.
  always @(negedge clk) begin
    if (rst_n && alu_start) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL launch_unexpected: got a=%h b=%h op=%b, required no launch", operand_a, operand_b, op_sel);
      end else begin
        launch_t e;
        e = sb_q.pop_front();
        if ({operand_a, operand_b, op_sel} !== {e.a, e.b, e.op}) begin
          n_fail++;
          $display("FAIL launch_operands: got a=%h b=%h op=%b, required a=%h b=%h op=%b",
                   operand_a, operand_b, op_sel, e.a, e.b, e.op);
        end
      end
      if (prev_start) begin
        n_checks++;
        n_fail++;
        $display("FAIL launch_width: got alu_start high 2 cycles, required 1");
      end
    end
    prev_start = alu_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic alu_respond(input logic [15:0] res, input logic err);
    alu_result = res;
    alu_err    = err;
    alu_done   = 1'b1;
    tick();
    alu_done   = 1'b0;
    alu_err    = 1'b0;
  endtask

  task automatic expect_launch(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    launch_t e;
    e.a = a; e.b = b; e.op = op;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({state_dbg, operand_a, operand_b, display, op_sel, digit_count, alu_start, error} !==
        {S_A, 16'h0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d a=%h b=%h d=%h op=%b cnt=%0d st=%b err=%b, required all zero",
               state_dbg, operand_a, operand_b, display, op_sel, digit_count, alu_start, error);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_add();
    press(4'h1); press(4'h2); press(4'h3);
    n_checks++;
    if ({digit_count, display, operand_a} !== {3'd3, 16'h0123, 16'h0123}) begin
      n_fail++;
      $display("FAIL digits_a: got cnt=%0d d=%h a=%h, required cnt=3 d=0123 a=0123", digit_count, display, operand_a);
    end
    press(4'hA);
    n_checks++;
    if ({state_dbg, digit_count, op_sel, operand_b} !== {S_B, 3'd0, 2'b00, 16'h0}) begin
      n_fail++;
      $display("FAIL op_add: got st=%0d cnt=%0d op=%b b=%h, required st=1 cnt=0 op=00 b=0000", state_dbg, digit_count, op_sel, operand_b);
    end
    press(4'h4); press(4'h5);
    n_checks++;
    if ({display, operand_b, digit_count} !== {16'h0045, 16'h0045, 3'd2}) begin
      n_fail++;
      $display("FAIL digits_b: got d=%h b=%h cnt=%0d, required d=0045 b=0045 cnt=2", display, operand_b, digit_count);
    end
    expect_launch(16'h0123, 16'h0045, 2'b00);
    press(4'hE);
    n_checks++;
    if ({alu_start, state_dbg} !== {1'b1, S_START}) begin
      n_fail++;
      $display("FAIL start_latency: got start=%b st=%0d, required start=1 st=2", alu_start, state_dbg);
    end
    tick();
    n_checks++;
    if ({alu_start, state_dbg} !== {1'b0, S_WAIT}) begin
      n_fail++;
      $display("FAIL start_pulse: got start=%b st=%0d, required start=0 st=3", alu_start, state_dbg);
    end
    alu_respond(16'h0168, 1'b0);
    n_checks++;
    if ({display, state_dbg, error} !== {16'h0168, S_SHOW, 1'b0}) begin
      n_fail++;
      $display("FAIL result_show: got d=%h st=%0d err=%b, required d=0168 st=4 err=0", display, state_dbg, error);
    end
  endtask

  task automatic test_chain();
    press(4'hB);
    n_checks++;
    if ({operand_a, operand_b, op_sel, state_dbg} !== {16'h0168, 16'h0, 2'b01, S_B}) begin
      n_fail++;
      $display("FAIL chain_op: got a=%h b=%h op=%b st=%0d, required a=0168 b=0000 op=01 st=1", operand_a, operand_b, op_sel, state_dbg);
    end
    press(4'h8);
    n_checks++;
    if ({operand_b, display} !== {16'h0008, 16'h0008}) begin
      n_fail++;
      $display("FAIL chain_digit: got b=%h d=%h, required b=0008 d=0008", operand_b, display);
    end
    expect_launch(16'h0168, 16'h0008, 2'b01);
    press(4'hE);
    tick();
    alu_respond(16'h0160, 1'b0);
    n_checks++;
    if ({display, state_dbg} !== {16'h0160, S_SHOW}) begin
      n_fail++;
      $display("FAIL chain_result: got d=%h st=%0d, required d=0160 st=4", display, state_dbg);
    end
  endtask

  task automatic test_show_keys();
    press(4'hD);
    press(4'hE);
    n_checks++;
    if ({display, state_dbg, alu_start} !== {16'h0160, S_SHOW, 1'b0}) begin
      n_fail++;
      $display("FAIL show_ignore: got d=%h st=%0d start=%b, required d=0160 st=4 start=0", display, state_dbg, alu_start);
    end
    press(4'h7);
    n_checks++;
    if ({state_dbg, operand_a, digit_count, display} !== {S_A, 16'h0007, 3'd1, 16'h0007}) begin
      n_fail++;
      $display("FAIL show_digit: got st=%0d a=%h cnt=%0d d=%h, required st=0 a=0007 cnt=1 d=0007", state_dbg, operand_a, digit_count, display);
    end
  endtask

  task automatic test_saturate();
    press(4'hF);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    n_checks++;
    if ({operand_a, digit_count} !== {16'h9876, 3'd4}) begin
      n_fail++;
      $display("FAIL four_digits: got a=%h cnt=%0d, required a=9876 cnt=4", operand_a, digit_count);
    end
    press(4'h5);
    press(4'hE);
    n_checks++;
    if ({operand_a, digit_count, display, state_dbg, alu_start} !== {16'h9876, 3'd4, 16'h9876, S_A, 1'b0}) begin
      n_fail++;
      $display("FAIL saturate: got a=%h cnt=%0d d=%h st=%0d start=%b, required a=9876 cnt=4 d=9876 st=0 start=0",
               operand_a, digit_count, display, state_dbg, alu_start);
    end
    press(4'hC);
    n_checks++;
    if ({op_sel, state_dbg, digit_count} !== {2'b10, S_B, 3'd0}) begin
      n_fail++;
      $display("FAIL op_mul: got op=%b st=%0d cnt=%0d, required op=10 st=1 cnt=0", op_sel, state_dbg, digit_count);
    end
  endtask

  task automatic test_timeout();
    expect_launch(16'h9876, 16'h0000, 2'b10);
    press(4'hE);
    repeat (16) tick();
    n_checks++;
    if ({state_dbg, error} !== {S_WAIT, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_early: got st=%0d err=%b, required st=3 err=0", state_dbg, error);
    end
    tick();
    n_checks++;
    if ({state_dbg, error, display} !== {S_ERR, 1'b1, 16'hEEEE}) begin
      n_fail++;
      $display("FAIL timeout_err: got st=%0d err=%b d=%h, required st=5 err=1 d=EEEE", state_dbg, error, display);
    end
    press(4'h5);
    n_checks++;
    if ({state_dbg, display} !== {S_ERR, 16'hEEEE}) begin
      n_fail++;
      $display("FAIL error_hold: got st=%0d d=%h, required st=5 d=EEEE", state_dbg, display);
    end
    press(4'hF);
    n_checks++;
    if ({state_dbg, operand_a, operand_b, display, op_sel, digit_count, error} !==
        {S_A, 16'h0, 16'h0, 16'h0, 2'b00, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_error: got st=%0d a=%h b=%h d=%h op=%b cnt=%0d err=%b, required all zero",
               state_dbg, operand_a, operand_b, display, op_sel, digit_count, error);
    end
  endtask

  task automatic test_alu_err();
    press(4'h1); press(4'hA); press(4'h1);
    expect_launch(16'h0001, 16'h0001, 2'b00);
    press(4'hE);
    tick();
    alu_respond(16'h0002, 1'b1);
    n_checks++;
    if ({state_dbg, error, display} !== {S_ERR, 1'b1, 16'hEEEE}) begin
      n_fail++;
      $display("FAIL alu_err: got st=%0d err=%b d=%h, required st=5 err=1 d=EEEE", state_dbg, error, display);
    end
    press(4'hF);
    press(4'h2); press(4'hA); press(4'h2);
    expect_launch(16'h0002, 16'h0002, 2'b00);
    press(4'hE);
    tick();
    key_code   = 4'hF;
    key_valid  = 1'b1;
    alu_result = 16'h0004;
    alu_done   = 1'b1;
    tick();
    key_valid  = 1'b0;
    alu_done   = 1'b0;
    n_checks++;
    if ({state_dbg, display, operand_a, error} !== {S_A, 16'h0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_vs_done: got st=%0d d=%h a=%h err=%b, required st=0 d=0000 a=0000 err=0", state_dbg, display, operand_a, error);
    end
  endtask

  task automatic test_reset_mid_wait();
    press(4'h3); press(4'hA); press(4'h4);
    expect_launch(16'h0003, 16'h0004, 2'b00);
    press(4'hE);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state_dbg, operand_a, operand_b, display, digit_count, alu_start} !==
        {S_A, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d a=%h b=%h d=%h cnt=%0d start=%b, required all zero",
               state_dbg, operand_a, operand_b, display, digit_count, alu_start);
    end
    tick();
    rst_n = 1'b1;
    tick();
    alu_respond(16'h0007, 1'b0);
    n_checks++;
    if ({state_dbg, display, error} !== {S_A, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL late_done: got st=%0d d=%h err=%b, required st=0 d=0000 err=0", state_dbg, display, error);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_chain();
    test_show_keys();
    test_saturate();
    test_timeout();
    test_alu_err();
    test_reset_mid_wait();
    repeat (2) tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_launch: got %0d launches outstanding, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
